// File: rtl/hssim_ratio.sv
// Per-pixel SSIM ratio stage: turns packed signed numerator/denominator lanes into
// unsigned Q1.OUT_FRAC weights using one bit-serial restoring divider per lane.
module hssim_ratio #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int NUMR_BIT_WIDTH  = 36,
  parameter int DENR_BIT_WIDTH  = 36,
  parameter int OUT_FRAC        = 16,
  parameter int NUMR_WIDTH      = NUMR_BIT_WIDTH * PIXELS_PER_BEAT,
  parameter int DENR_WIDTH      = DENR_BIT_WIDTH * PIXELS_PER_BEAT,
  parameter int OUT_WIDTH       = (OUT_FRAC + 1) * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUMR_WIDTH-1:0] numr_in,
  input  logic [DENR_WIDTH-1:0] denr_in,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  weight_out,
  output logic                  out_last
);

  // state | meaning
  // IDLE  | waiting for a beat
  // DIV   | one quotient bit per lane per cycle, OUT_FRAC cycles
  // DONE  | result held in weight_out until downstream consumes it (stall low)

  localparam int LW  = OUT_FRAC + 1;
  localparam int RW  = DENR_BIT_WIDTH + 1;
  localparam int CW  = $clog2(OUT_FRAC) + 1;
  localparam int PPB = PIXELS_PER_BEAT;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [RW-1:0]             r_rem [PPB];
  logic [DENR_BIT_WIDTH-1:0] r_den [PPB];
  logic [OUT_FRAC-2:0]       r_q   [PPB];
  logic [PPB-1:0]            r_one;
  logic [PPB-1:0]            r_zero;
  logic                      r_last;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic [OUT_WIDTH-1:0]      r_weight;

  logic                      w_accept;
  logic [PPB-1:0]            w_one_init;
  logic [PPB-1:0]            w_zero_init;
  logic [PPB-1:0]            w_qbit;
  logic [RW-1:0]             w_rem_init [PPB];
  logic [RW-1:0]             w_rem_next [PPB];
  logic [DENR_BIT_WIDTH-1:0] w_den_init [PPB];
  logic [OUT_WIDTH-1:0]      w_lane_w;

  assign in_ready   = !reset && ((r_state == S_IDLE) || (r_state == S_DONE && !stall));
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign weight_out = r_weight;

  for (genvar g = 0; g < PPB; g++) begin : g_lane
    logic signed [NUMR_BIT_WIDTH-1:0] w_n;
    logic signed [DENR_BIT_WIDTH-1:0] w_d;
    logic [RW-1:0]                    w_rem2;
    logic [RW-1:0]                    w_den_ext;

    assign w_n = numr_in[g*NUMR_BIT_WIDTH +: NUMR_BIT_WIDTH];
    assign w_d = denr_in[g*DENR_BIT_WIDTH +: DENR_BIT_WIDTH];

    // Saturated lanes still run the divider on a zero remainder so every lane finishes together.
    assign w_one_init[g]  = (w_n == 0 && w_d == 0) || (w_n >= 0 && (w_d <= 0 || w_n >= w_d));
    assign w_zero_init[g] = (w_n < 0);
    assign w_rem_init[g]  = (w_one_init[g] || w_zero_init[g]) ? '0 : RW'($unsigned(w_n));
    assign w_den_init[g]  = $unsigned(w_d);

    assign w_rem2        = r_rem[g] << 1;
    assign w_den_ext     = RW'(r_den[g]);
    assign w_qbit[g]     = (w_rem2 >= w_den_ext);
    assign w_rem_next[g] = w_qbit[g] ? (w_rem2 - w_den_ext) : w_rem2;

    assign w_lane_w[g*LW +: LW] = r_one[g]  ? {1'b1, {OUT_FRAC{1'b0}}} :
                                  r_zero[g] ? '0 :
                                              {1'b0, r_q[g], w_qbit[g]};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PPB; i++) begin
      if (w_accept) begin
        r_rem[i] <= w_rem_init[i];
        r_den[i] <= w_den_init[i];
        r_q[i]   <= '0;
      end else if (r_state == S_DIV) begin
        r_rem[i] <= w_rem_next[i];
        r_q[i]   <= {r_q[i][OUT_FRAC-3:0], w_qbit[i]};
      end
    end
    if (w_accept) begin
      r_one  <= w_one_init;
      r_zero <= w_zero_init;
      r_last <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_weight    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_DIV;
            r_cnt   <= '0;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(OUT_FRAC - 1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_last  <= r_last;
            r_weight    <= w_lane_w;
          end
        end
        S_DONE: begin
          if (!stall) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_state <= S_DIV;
              r_cnt   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hssim_ratio.sv
// Directed and randomized bench for hssim_ratio; expected weights come from an
// arithmetic model of the classification rules and floor division.
module tb_hssim_ratio;
  localparam int PPB = 16;
  localparam int NB  = 36;
  localparam int DB  = 36;
  localparam int OF  = 16;
  localparam int LW  = OF + 1;
  localparam int NW  = NB * PPB;
  localparam int DW  = DB * PPB;
  localparam int OW  = LW * PPB;
  localparam int N_RAND = 2000;

  logic          clk = 1'b0;
  logic          reset, stall, in_valid, in_last;
  logic [NW-1:0] numr_in;
  logic [DW-1:0] denr_in;
  logic          in_ready, out_valid, out_last;
  logic [OW-1:0] weight_out;

  int            n_checks = 0;
  int            n_fail   = 0;
  longint        nv [PPB];
  longint        dv [PPB];
  logic [OW-1:0] exp_w;
  logic [OW-1:0] exp_hold;
  int            lat;

  always #5 clk = ~clk;

  hssim_ratio dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .numr_in    (numr_in),
    .denr_in    (denr_in),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .weight_out (weight_out),
    .out_last   (out_last)
  );

  function automatic logic [LW-1:0] ref_lane(longint n, longint d);
    if (n == 0 && d == 0) return LW'(longint'(1) << OF);
    if (n < 0)            return '0;
    if (d <= 0)           return LW'(longint'(1) << OF);
    if (n >= d)           return LW'(longint'(1) << OF);
    return LW'((n * (longint'(1) << OF)) / d);
  endfunction

  function automatic longint sx(logic [NB-1:0] x);
    return longint'($signed(x));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_beat(logic last);
    logic [63:0] t;
    for (int i = 0; i < PPB; i++) begin
      t = nv[i];
      numr_in[i*NB +: NB] = t[NB-1:0];
      t = dv[i];
      denr_in[i*DB +: DB] = t[DB-1:0];
      exp_w[i*LW +: LW] = ref_lane(nv[i], dv[i]);
    end
    in_last = last;
  endtask

  task automatic send();
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("handshake_wait", OW'(in_ready), OW'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic rand_lanes();
    logic [63:0] r1, r2;
    for (int i = 0; i < PPB; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: begin
          nv[i] = sx(r1[NB-1:0]);
          dv[i] = sx(r2[NB-1:0]);
        end
        1: begin
          dv[i] = longint'(r2[33:0]) + 1;
          nv[i] = longint'(r1[34:0]) % dv[i];
        end
        2: begin
          nv[i] = longint'($urandom_range(0, 8)) - 4;
          dv[i] = longint'($urandom_range(0, 8)) - 4;
        end
        default: begin
          dv[i] = longint'(r2[33:0]) + 2;
          nv[i] = dv[i] - longint'($urandom_range(0, 1));
        end
      endcase
    end
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    numr_in  = '0;
    denr_in  = '0;
    tick();
    tick();
    check("rst_in_ready", OW'(in_ready), OW'(0));
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_weight", weight_out, '0);
    check("rst_out_last", OW'(out_last), OW'(0));
    reset = 1'b0;
    #1;
    check("idle_in_ready", OW'(in_ready), OW'(1));

    // Basic fractions; unused lanes 0/0 saturate to 1.0.
    for (int i = 0; i < PPB; i++) begin nv[i] = 0; dv[i] = 0; end
    nv[0] = 1; dv[0] = 2;
    nv[1] = 3; dv[1] = 4;
    nv[2] = 1; dv[2] = 3;
    load_beat(1'b0);
    send();
    check("busy_in_ready", OW'(in_ready), OW'(0));
    wait_out(lat);
    check("basic_latency", OW'(lat), OW'(16));
    check("basic_lane0", OW'(weight_out[0*LW +: LW]), OW'(32768));
    check("basic_lane1", OW'(weight_out[1*LW +: LW]), OW'(49152));
    check("basic_lane2", OW'(weight_out[2*LW +: LW]), OW'(21845));
    check("basic_all", weight_out, exp_w);
    check("basic_last", OW'(out_last), OW'(0));
    tick();
    check("basic_consumed", OW'(out_valid), OW'(0));
    check("basic_idle_ready", OW'(in_ready), OW'(1));

    // Saturating classifications mixed with ordinary divisions.
    for (int i = 0; i < PPB; i++) begin nv[i] = i; dv[i] = i + 7; end
    nv[0] = -5; dv[0] = 100;
    nv[1] = 0;  dv[1] = 0;
    nv[2] = 10; dv[2] = 3;
    nv[3] = 7;  dv[3] = 0;
    load_beat(1'b1);
    send();
    wait_out(lat);
    check("special_latency", OW'(lat), OW'(16));
    check("special_lane0", OW'(weight_out[0*LW +: LW]), OW'(0));
    check("special_lane1", OW'(weight_out[1*LW +: LW]), OW'(65536));
    check("special_lane2", OW'(weight_out[2*LW +: LW]), OW'(65536));
    check("special_lane3", OW'(weight_out[3*LW +: LW]), OW'(65536));
    check("special_all", weight_out, exp_w);
    check("special_last", OW'(out_last), OW'(1));
    tick();

    // Back-to-back beats with in_valid held high.
    rand_lanes();
    load_beat(1'b0);
    exp_hold = exp_w;
    in_valid = 1'b1;
    check("b2b_ready0", OW'(in_ready), OW'(1));
    tick();
    rand_lanes();
    load_beat(1'b1);
    lat = 0;
    while (!in_ready && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b_ready_gap", OW'(lat), OW'(16));
    check("b2b_a_valid", OW'(out_valid), OW'(1));
    check("b2b_a_weight", weight_out, exp_hold);
    check("b2b_a_last", OW'(out_last), OW'(0));
    tick();
    in_valid = 1'b0;
    check("b2b_b_accepted_valid", OW'(out_valid), OW'(0));
    check("b2b_b_accepted_ready", OW'(in_ready), OW'(0));
    wait_out(lat);
    check("b2b_b_latency", OW'(lat), OW'(16));
    check("b2b_b_weight", weight_out, exp_w);
    check("b2b_b_last", OW'(out_last), OW'(1));
    tick();

    // Stall holds a finished result while a new beat waits.
    rand_lanes();
    load_beat(1'b1);
    exp_hold = exp_w;
    send();
    wait_out(lat);
    check("stall_latency", OW'(lat), OW'(16));
    stall = 1'b1;
    rand_lanes();
    load_beat(1'b0);
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_in_ready", OW'(in_ready), OW'(0));
      check("stall_valid", OW'(out_valid), OW'(1));
      check("stall_weight", weight_out, exp_hold);
      check("stall_last", OW'(out_last), OW'(1));
      tick();
    end
    stall = 1'b0;
    #1;
    check("unstall_ready", OW'(in_ready), OW'(1));
    tick();
    in_valid = 1'b0;
    check("unstall_accept_valid", OW'(out_valid), OW'(0));
    check("unstall_accept_ready", OW'(in_ready), OW'(0));
    wait_out(lat);
    check("unstall_latency", OW'(lat), OW'(16));
    check("unstall_weight", weight_out, exp_w);
    check("unstall_last", OW'(out_last), OW'(0));
    tick();

    // Reset landing on the eighth DIV edge aborts the beat.
    rand_lanes();
    load_beat(1'b1);
    send();
    for (int k = 0; k < 7; k++) tick();
    reset = 1'b1;
    tick();
    check("abort_rst_ready", OW'(in_ready), OW'(0));
    check("abort_valid", OW'(out_valid), OW'(0));
    check("abort_weight", weight_out, '0);
    reset = 1'b0;
    #1;
    check("abort_idle_ready", OW'(in_ready), OW'(1));
    for (int k = 0; k < 12; k++) tick();
    check("abort_no_output", OW'(out_valid), OW'(0));
    check("abort_last", OW'(out_last), OW'(0));
    for (int i = 0; i < PPB; i++) begin nv[i] = 1; dv[i] = 4; end
    load_beat(1'b0);
    send();
    wait_out(lat);
    check("fresh_latency", OW'(lat), OW'(16));
    check("fresh_lane0", OW'(weight_out[0*LW +: LW]), OW'(16384));
    check("fresh_all", weight_out, exp_w);
    tick();

    // Randomized beats with occasional short stalls.
    for (int b = 0; b < N_RAND; b++) begin
      rand_lanes();
      load_beat(1'($urandom_range(0, 1)));
      exp_hold = {{(OW-1){1'b0}}, in_last};
      send();
      wait_out(lat);
      check("rand_latency", OW'(lat), OW'(16));
      if ($urandom_range(0, 7) == 0) begin
        stall = 1'b1;
        tick();
        stall = 1'b0;
      end
      check("rand_weight", weight_out, exp_w);
      check("rand_last", OW'(out_last), exp_hold);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
